// File: rtl/hs_dpath_piso_hs.sv
// Parallel-in serial-out stage: takes one WORDS-element word on the slave
// handshake and replays it one element per beat on the master handshake.
module hs_dpath_piso_hs #(
    parameter type         DATA_TYPE   = logic,
    parameter DATA_TYPE    RESET_VALUE = 1'b0,
    parameter int unsigned WORDS       = 4,
    parameter bit          LSB_FIRST   = 1'b1
) (
    input  logic     clk,
    input  logic     sreset,
    input  logic     ce,
    input  logic     s_valid,
    output logic     s_ready,
    input  DATA_TYPE s_data [WORDS],
    output logic     m_valid,
    input  logic     m_ready,
    output DATA_TYPE m_data,
    output logic     m_last
);

    localparam int unsigned   CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    DATA_TYPE      buffer [WORDS];
    logic          load;
    logic          advance;

    always_comb begin
        idx    = LSB_FIRST ? count : (LAST - count);
        m_data = buffer[idx];
    end

    // The final beat's acceptance doubles as the reload slot, so
    // back-to-back words stream without a bubble.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        case (state)
            IDLE: begin
                s_ready = ce;
                if (ce && s_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                m_valid = 1'b1;
                m_last  = (count == LAST);
                s_ready = ce && m_last && m_ready;
                if (ce && m_ready) begin
                    if (!m_last)
                        advance = 1'b1;
                    else if (s_valid)
                        load = 1'b1;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state <= IDLE;
            count <= '0;
            for (int unsigned i = 0; i < WORDS; i++)
                buffer[i] <= RESET_VALUE;
        end else if (ce) begin
            state <= state_next;
            if (load) begin
                buffer <= s_data;
                count  <= '0;
            end else if (advance) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hs_dpath_piso_hs.sv
// Bench for hs_dpath_piso_hs: three variants (LSB-first, MSB-first, single
// beat) share one stimulus stream and are checked against a queue model.
module tb_hs_dpath_piso_hs;

    logic             clk = 1'b0;
    logic             sreset, ce, s_valid, m_ready;
    logic [7:0]       sd  [4];
    logic [7:0]       sd1 [1];
    logic [2:0]       mv, ml, sr;
    logic [2:0][7:0]  md;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t q [3][$];

    always #5 clk = ~clk;

    assign sd1[0] = sd[0];

    hs_dpath_piso_hs #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'h00), .WORDS(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .sreset(sreset), .ce(ce), .s_valid(s_valid), .s_ready(sr[0]), .s_data(sd),
        .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .m_last(ml[0]));

    hs_dpath_piso_hs #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'h00), .WORDS(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .sreset(sreset), .ce(ce), .s_valid(s_valid), .s_ready(sr[1]), .s_data(sd),
        .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .m_last(ml[1]));

    hs_dpath_piso_hs #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'h00), .WORDS(1), .LSB_FIRST(1'b1)) u_one (
        .clk(clk), .sreset(sreset), .ce(ce), .s_valid(s_valid), .s_ready(sr[2]), .s_data(sd1),
        .m_valid(mv[2]), .m_ready(m_ready), .m_data(md[2]), .m_last(ml[2]));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_sready(input int k);
        return ce && (q[k].size() == 0 || (q[k].size() == 1 && m_ready));
    endfunction

    // Model: each accepted word becomes a queue of pending beats.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sreset) begin
                q[k].delete();
            end else if (ce) begin
                logic acc;
                int   wl;
                acc = s_valid && model_sready(k);
                if (q[k].size() != 0 && m_ready)
                    void'(q[k].pop_front());
                if (acc) begin
                    wl = (k == 2) ? 1 : 4;
                    for (int i = 0; i < wl; i++) begin
                        beat_t b;
                        b.d = sd[(k == 1) ? (3 - i) : i];
                        b.l = (i == wl - 1);
                        q[k].push_back(b);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("model_m_valid[%0d]", k), 32'(mv[k]), 32'(q[k].size() != 0));
            cmp($sformatf("model_s_ready[%0d]", k), 32'(sr[k]), 32'(model_sready(k)));
            if (q[k].size() != 0) begin
                cmp($sformatf("model_m_data[%0d]", k), 32'(md[k]), 32'(q[k][0].d));
                cmp($sformatf("model_m_last[%0d]", k), 32'(ml[k]), 32'(q[k][0].l));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] base);
        for (int i = 0; i < 4; i++)
            sd[i] = base + 8'(i);
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        @(negedge clk);
        cmp("lit_m_valid", 32'(mv[0]), 32'd1);
        cmp("lit_m_data", 32'(md[0]), 32'(d));
        cmp("lit_m_last", 32'(ml[0]), 32'(l));
    endtask

    task automatic idle_chk();
        @(negedge clk);
        cmp("lit_idle_m_valid", 32'(mv[0]), 32'd0);
    endtask

    initial begin
        sreset = 1'b1; ce = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        load_word(8'h00);
        cyc(); cyc();
        @(negedge clk);
        cmp("rst_m_valid", 32'(mv[0]), 32'd0);
        cmp("rst_m_data", 32'(md[0]), 32'h00);
        cmp("rst_m_last", 32'(ml[0]), 32'd0);
        cmp("rst_s_ready", 32'(sr[0]), 32'd1);

        // single word, LSB first / MSB first / single-beat
        cyc(); sreset = 1'b0; s_valid = 1'b1; load_word(8'h00);
        cyc(); s_valid = 1'b0;
        beat(8'h00, 1'b0);
        cmp("msb_beat0", 32'(md[1]), 32'h03);
        cmp("one_data", 32'(md[2]), 32'h00);
        cmp("one_last", 32'(ml[2]), 32'd1);
        cyc(); beat(8'h01, 1'b0);
        cmp("msb_beat1", 32'(md[1]), 32'h02);
        cmp("one_done", 32'(mv[2]), 32'd0);
        cyc(); beat(8'h02, 1'b0);
        cmp("msb_beat2", 32'(md[1]), 32'h01);
        cyc(); beat(8'h03, 1'b1);
        cmp("lit_s_ready_last", 32'(sr[0]), 32'd1);
        cmp("msb_beat3", 32'(md[1]), 32'h00);
        cmp("msb_last", 32'(ml[1]), 32'd1);
        cyc(); idle_chk();

        // back-to-back words
        cyc(); s_valid = 1'b1; load_word(8'h10);
        cyc(); beat(8'h10, 1'b0);
        cyc(); beat(8'h11, 1'b0);
        cyc(); beat(8'h12, 1'b0);
        cmp("one_stream_valid", 32'(mv[2]), 32'd1);
        cmp("one_stream_data", 32'(md[2]), 32'h10);
        cyc(); load_word(8'h20); beat(8'h13, 1'b1);
        cmp("lit_s_ready_b2b", 32'(sr[0]), 32'd1);
        cyc(); beat(8'h20, 1'b0);
        cyc(); beat(8'h21, 1'b0);
        cyc(); beat(8'h22, 1'b0);
        cyc(); s_valid = 1'b0; beat(8'h23, 1'b1);
        cyc(); idle_chk();

        // backpressure on beat 01
        cyc(); s_valid = 1'b1; load_word(8'h30);
        cyc(); s_valid = 1'b0; beat(8'h30, 1'b0);
        cyc(); m_ready = 1'b0; beat(8'h31, 1'b0);
        cyc(); beat(8'h31, 1'b0);
        cyc(); beat(8'h31, 1'b0);
        cyc(); m_ready = 1'b1; beat(8'h31, 1'b0);
        cyc(); beat(8'h32, 1'b0);
        cyc(); beat(8'h33, 1'b1);
        cyc(); idle_chk();

        // clock enable low mid-word with toggling inputs
        cyc(); s_valid = 1'b1; load_word(8'h40);
        cyc(); s_valid = 1'b0; beat(8'h40, 1'b0);
        cyc(); beat(8'h41, 1'b0);
        cyc(); ce = 1'b0; s_valid = 1'b1; m_ready = 1'b0; load_word(8'h50);
        beat(8'h42, 1'b0);
        cmp("ce0_s_ready", 32'(sr[0]), 32'd0);
        cyc(); s_valid = 1'b0; m_ready = 1'b1;
        beat(8'h42, 1'b0);
        cmp("ce0_s_ready2", 32'(sr[0]), 32'd0);
        cyc(); ce = 1'b1; beat(8'h42, 1'b0);
        cyc(); beat(8'h43, 1'b1);
        cyc(); idle_chk();

        // reset mid-word
        cyc(); s_valid = 1'b1; load_word(8'h60);
        cyc(); s_valid = 1'b0; beat(8'h60, 1'b0);
        cyc(); beat(8'h61, 1'b0);
        cyc(); sreset = 1'b1;
        cyc(); sreset = 1'b0; s_valid = 1'b1; load_word(8'h70);
        @(negedge clk);
        cmp("rst2_m_valid", 32'(mv[0]), 32'd0);
        cmp("rst2_m_data", 32'(md[0]), 32'h00);
        cmp("rst2_m_last", 32'(ml[0]), 32'd0);
        cmp("rst2_s_ready", 32'(sr[0]), 32'd1);
        cyc(); s_valid = 1'b0; beat(8'h70, 1'b0);
        cyc(); beat(8'h71, 1'b0);
        cyc(); beat(8'h72, 1'b0);
        cyc(); beat(8'h73, 1'b1);
        cyc(); idle_chk();

        // mixed traffic, checked by the model only
        for (int n = 0; n < 300; n++) begin
            cyc();
            ce      = ($urandom_range(0, 9) != 0);
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            sreset  = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < 4; i++)
                sd[i] = 8'($urandom);
        end
        cyc(); sreset = 1'b0; ce = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        repeat (6) cyc();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
